// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative RV32M/RV64M multiply/divide beside the EX-stage ALU, one bit per cycle.
// Latency: XLEN+2 cycles of EX occupancy; 2 cycles for divide-by-zero and signed overflow.
// Backpressure: stall_op holds IF/ID/EX until the DONE cycle; flush_ip aborts immediately.
// Ports: clock, reset (sync, active-high); md_enable_ip, md_operator_ip (funct3), md_operand_a_ip/_b_ip,
//        fa_mux_ip/fb_mux_ip with fw_mem_data/fw_wb_data forwarding, md_rd_addr_ip, flush_ip in;
//        stall_op, md_result_op, md_valid_op, md_rd_addr_op, md_busy_op out.
module ex_muldiv_unit #(
   parameter int XLEN  = 32,
   parameter int CNT_W = $clog2(XLEN) + 1
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            md_enable_ip,
   input  logic [2:0]      md_operator_ip,
   input  logic [XLEN-1:0] md_operand_a_ip,
   input  logic [XLEN-1:0] md_operand_b_ip,
   input  logic [1:0]      fa_mux_ip,
   input  logic [1:0]      fb_mux_ip,
   input  logic [XLEN-1:0] fw_mem_data,
   input  logic [XLEN-1:0] fw_wb_data,
   input  logic [4:0]      md_rd_addr_ip,
   input  logic            flush_ip,
   output logic            stall_op,
   output logic [XLEN-1:0] md_result_op,
   output logic            md_valid_op,
   output logic [4:0]      md_rd_addr_op,
   output logic            md_busy_op
);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   state_t              state;
   logic [2:0]          op_q;
   logic                neg_q;
   logic [CNT_W-1:0]    cnt;
   logic [XLEN-1:0]     opnd;      // multiplicand (MUL) or divisor (DIV), as a magnitude
   logic [2*XLEN-1:0]   acc;       // MUL: {partial sum, multiplier}; DIV: {remainder, dividend/quotient}

   // Operand selection and start-of-operation decode
   logic [XLEN-1:0]     a_sel, b_sel, a_mag, b_mag;
   logic                a_sgn, b_sgn, a_neg, b_neg, neg_start, div_zero, div_ovf;

   always_comb begin
      case (fa_mux_ip)
         2'd1:    a_sel = fw_mem_data;
         2'd2:    a_sel = fw_wb_data;
         default: a_sel = md_operand_a_ip;
      endcase
      case (fb_mux_ip)
         2'd1:    b_sel = fw_mem_data;
         2'd2:    b_sel = fw_wb_data;
         default: b_sel = md_operand_b_ip;
      endcase
      // Signed operands: MUL/MULH both, MULHSU a only, DIV/REM both
      if (md_operator_ip[2]) begin
         a_sgn = ~md_operator_ip[0];
         b_sgn = ~md_operator_ip[0];
      end else begin
         a_sgn = (md_operator_ip != 3'd3);
         b_sgn = ~md_operator_ip[1];
      end
      a_neg = a_sgn & a_sel[XLEN-1];
      b_neg = b_sgn & b_sel[XLEN-1];
      a_mag = a_neg ? -a_sel : a_sel;
      b_mag = b_neg ? -b_sel : b_sel;
      // Remainder follows the dividend; everything else follows the product/quotient sign
      neg_start = (md_operator_ip == 3'd6) ? a_neg : (a_neg ^ b_neg);
      div_zero  = md_operator_ip[2] & (b_sel == '0);
      div_ovf   = md_operator_ip[2] & ~md_operator_ip[0] & (a_sel == MIN_NEG) & (&b_sel);
   end

   // One iteration of shift-add (MUL) or restoring shift-subtract (DIV)
   logic [XLEN:0]       mul_sum, div_shift, div_diff;
   logic [2*XLEN-1:0]   acc_nxt, prod_fix;
   logic [XLEN-1:0]     quo_fix, rem_fix, res_nxt;
   logic                last;

   always_comb begin
      mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});
      div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
      div_diff  = div_shift - {1'b0, opnd};
      if (state == S_MUL)
         acc_nxt = {mul_sum, acc[XLEN-1:1]};
      else if (!div_diff[XLEN])
         acc_nxt = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      else
         acc_nxt = {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};

      prod_fix = neg_q ? -acc_nxt : acc_nxt;
      quo_fix  = neg_q ? -acc_nxt[XLEN-1:0] : acc_nxt[XLEN-1:0];
      rem_fix  = neg_q ? -acc_nxt[2*XLEN-1:XLEN] : acc_nxt[2*XLEN-1:XLEN];
      case (op_q)
         3'd0:       res_nxt = prod_fix[XLEN-1:0];
         3'd1, 3'd2,
         3'd3:       res_nxt = prod_fix[2*XLEN-1:XLEN];
         3'd4, 3'd5: res_nxt = quo_fix;
         default:    res_nxt = rem_fix;
      endcase
      last = (cnt == CNT_W'(XLEN-1));
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state         <= S_IDLE;
         op_q          <= '0;
         neg_q         <= 1'b0;
         cnt           <= '0;
         opnd          <= '0;
         acc           <= '0;
         md_result_op  <= '0;
         md_rd_addr_op <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (md_enable_ip && !flush_ip) begin
                  op_q          <= md_operator_ip;
                  md_rd_addr_op <= md_rd_addr_ip;
                  neg_q         <= neg_start;
                  cnt           <= '0;
                  if (div_zero) begin
                     md_result_op <= md_operator_ip[1] ? a_sel : '1;
                     state        <= S_DONE;
                  end else if (div_ovf) begin
                     md_result_op <= md_operator_ip[1] ? '0 : a_sel;
                     state        <= S_DONE;
                  end else if (md_operator_ip[2]) begin
                     opnd  <= b_mag;
                     acc   <= {{XLEN{1'b0}}, a_mag};
                     state <= S_DIV;
                  end else begin
                     opnd  <= a_mag;
                     acc   <= {{XLEN{1'b0}}, b_mag};
                     state <= S_MUL;
                  end
               end
            end
            S_MUL, S_DIV: begin
               if (flush_ip) begin
                  state <= S_IDLE;
               end else begin
                  acc <= acc_nxt;
                  cnt <= cnt + 1'b1;
                  if (last) begin
                     md_result_op <= res_nxt;
                     state        <= S_DONE;
                  end
               end
            end
            // DONE always returns to IDLE, flushed or not; a held enable does not restart here
            default: state <= S_IDLE;
         endcase
      end
   end

   assign stall_op    = ~flush_ip & (((state == S_IDLE) & md_enable_ip) | (state == S_MUL) | (state == S_DIV));
   assign md_valid_op = (state == S_DONE) & ~flush_ip;
   assign md_busy_op  = (state != S_IDLE);

endmodule

// File: tb/tb_ex_muldiv_unit.sv
module tb_ex_muldiv_unit;
   localparam int XLEN = 32;

   logic            clock = 1'b0;
   logic            reset;
   logic            md_enable_ip;
   logic [2:0]      md_operator_ip;
   logic [XLEN-1:0] md_operand_a_ip, md_operand_b_ip;
   logic [1:0]      fa_mux_ip, fb_mux_ip;
   logic [XLEN-1:0] fw_mem_data, fw_wb_data;
   logic [4:0]      md_rd_addr_ip;
   logic            flush_ip;
   logic            stall_op;
   logic [XLEN-1:0] md_result_op;
   logic            md_valid_op;
   logic [4:0]      md_rd_addr_op;
   logic            md_busy_op;

   int total = 0;
   int bad   = 0;

   always #5 clock = ~clock;

   ex_muldiv_unit #(.XLEN(XLEN)) dut (
      .clock(clock), .reset(reset), .md_enable_ip(md_enable_ip), .md_operator_ip(md_operator_ip),
      .md_operand_a_ip(md_operand_a_ip), .md_operand_b_ip(md_operand_b_ip),
      .fa_mux_ip(fa_mux_ip), .fb_mux_ip(fb_mux_ip), .fw_mem_data(fw_mem_data), .fw_wb_data(fw_wb_data),
      .md_rd_addr_ip(md_rd_addr_ip), .flush_ip(flush_ip), .stall_op(stall_op),
      .md_result_op(md_result_op), .md_valid_op(md_valid_op), .md_rd_addr_op(md_rd_addr_op),
      .md_busy_op(md_busy_op)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] fwd_sel(input logic [1:0] s, input logic [31:0] dec, mem, wb);
      return (s == 2'd1) ? mem : (s == 2'd2) ? wb : dec;
   endfunction

   // Reference: plain 64-bit arithmetic on the RISC-V M-extension definitions
   function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a, b);
      longint          sa, sb;
      longint unsigned ua, ub;
      logic [63:0]     p;
      int              q;
      bit              ovf;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      ua  = {32'd0, a};
      ub  = {32'd0, b};
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      case (op)
         3'd0: begin p = sa * sb; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * longint'(ub); return p[63:32]; end
         3'd3: begin p = ua * ub; return p[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (ovf) return a;
            q = $signed(a) / $signed(b); return q;
         end
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 0) return a;
            if (ovf) return 32'd0;
            q = $signed(a) % $signed(b); return q;
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   // Issue one M instruction the cycle after the previous one's DONE, follow it to completion.
   // flush_at > 0 raises flush_ip in that cycle (counted from the issue cycle 0).
   task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a, b,
                         input logic [1:0] fa, fb, input logic [31:0] mem, wb,
                         input logic [4:0] rd, input logic [31:0] exp_res, input int flush_at);
      logic [31:0] ea, eb;
      int          exp_lat;
      int          cyc;
      bit          stall_ok, fin, stray_vld;
      ea      = fwd_sel(fa, a, mem, wb);
      eb      = fwd_sel(fb, b, mem, wb);
      exp_lat = (op[2] && (eb == 0 || (!op[0] && ea == 32'h8000_0000 && eb == 32'hFFFF_FFFF))) ? 1 : XLEN + 1;
      @(posedge clock); #1;
      chk({tag, "_idle_vld"}, md_valid_op, 0);
      chk({tag, "_idle_busy"}, md_busy_op, 0);
      md_enable_ip = 1'b1; md_operator_ip = op; md_operand_a_ip = a; md_operand_b_ip = b;
      fa_mux_ip = fa; fb_mux_ip = fb; fw_mem_data = mem; fw_wb_data = wb; md_rd_addr_ip = rd;
      #1;
      chk({tag, "_stall_c0"}, stall_op, 1);
      stall_ok = 1'b1; fin = 1'b0; cyc = 0;
      while (!fin && cyc < XLEN + 6) begin
         @(posedge clock); #1;
         cyc++;
         if (cyc == 1) begin
            // Operands must have been captured already
            md_operand_a_ip = $urandom; md_operand_b_ip = $urandom;
            fw_mem_data = $urandom; fw_wb_data = $urandom; md_rd_addr_ip = 5'($urandom);
         end
         if (cyc == flush_at) begin
            flush_ip = 1'b1; #1;
            chk({tag, "_flush_stall"}, stall_op, 0);
            chk({tag, "_flush_vld"}, md_valid_op, 0);
            @(posedge clock); #1;
            flush_ip = 1'b0; md_enable_ip = 1'b0;
            chk({tag, "_flush_busy"}, md_busy_op, 0);
            stray_vld = 1'b0;
            for (int k = 0; k < 4; k++) begin
               @(posedge clock); #1;
               if (md_valid_op) stray_vld = 1'b1;
            end
            chk({tag, "_flush_novld"}, stray_vld, 0);
            fin = 1'b1;
         end else if (md_valid_op) begin
            chk({tag, "_res"}, md_result_op, exp_res);
            chk({tag, "_rd"}, md_rd_addr_op, rd);
            chk({tag, "_lat"}, cyc, exp_lat);
            chk({tag, "_stall_done"}, stall_op, 0);
            chk({tag, "_stall_busy"}, stall_ok, 1);
            md_enable_ip = 1'b0;
            fin = 1'b1;
         end else if (!stall_op) begin
            stall_ok = 1'b0;
         end
      end
      if (!fin) begin
         chk({tag, "_timeout"}, cyc, exp_lat);
         md_enable_ip = 1'b0;
      end
   endtask

   initial begin
      logic [2:0]  r_op;
      logic [31:0] r_a, r_b, r_m, r_w;
      logic [1:0]  r_fa, r_fb;

      reset = 1'b1; md_enable_ip = 1'b0; md_operator_ip = '0; md_operand_a_ip = '0; md_operand_b_ip = '0;
      fa_mux_ip = '0; fb_mux_ip = '0; fw_mem_data = '0; fw_wb_data = '0; md_rd_addr_ip = '0; flush_ip = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      reset = 1'b0;
      chk("rst_res", md_result_op, 0);
      chk("rst_vld", md_valid_op, 0);
      chk("rst_rd", md_rd_addr_op, 0);
      chk("rst_busy", md_busy_op, 0);
      chk("rst_stall", stall_op, 0);

      // Directed cases with hand-derived results
      run_op("mul",       3'd0, 32'd7,          32'hFFFF_FFFD, 2'd0, 2'd0, 0, 0, 5'd1,  32'hFFFF_FFEB, 0);
      run_op("mulhu",     3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 2'd0, 2'd0, 0, 0, 5'd2,  32'hFFFF_FFFE, 0);
      run_op("mulh",      3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 2'd0, 2'd0, 0, 0, 5'd3,  32'h0000_0000, 0);
      run_op("mulhsu",    3'd2, 32'hFFFF_FFFF,  32'd2,         2'd0, 2'd0, 0, 0, 5'd4,  32'hFFFF_FFFF, 0);
      run_op("div",       3'd4, 32'hFFFF_FFEC,  32'd3,         2'd0, 2'd0, 0, 0, 5'd5,  32'hFFFF_FFFA, 0);
      run_op("rem",       3'd6, 32'hFFFF_FFEC,  32'd3,         2'd0, 2'd0, 0, 0, 5'd6,  32'hFFFF_FFFE, 0);
      run_op("divu",      3'd5, 32'd100,        32'd7,         2'd0, 2'd0, 0, 0, 5'd7,  32'd14,        0);
      run_op("divu_z",    3'd5, 32'd5,          32'd0,         2'd0, 2'd0, 0, 0, 5'd8,  32'hFFFF_FFFF, 0);
      run_op("rem_z",     3'd6, 32'd5,          32'd0,         2'd0, 2'd0, 0, 0, 5'd9,  32'd5,         0);
      run_op("div_ovf",   3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 2'd0, 2'd0, 0, 0, 5'd10, 32'h8000_0000, 0);
      run_op("rem_ovf",   3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 2'd0, 2'd0, 0, 0, 5'd11, 32'd0,         0);
      run_op("fwd",       3'd0, 32'd100,        32'd200,       2'd1, 2'd2, 32'd9, 32'd6, 5'd12, 32'd54, 0);
      run_op("div_flush", 3'd4, 32'd1000,       32'd7,         2'd0, 2'd0, 0, 0, 5'd13, 32'd0,         10);
      run_op("mul_after", 3'd0, 32'd3,          32'd4,         2'd0, 2'd0, 0, 0, 5'd14, 32'd12,        0);
      run_op("done_flush",3'd5, 32'd77,         32'd5,         2'd0, 2'd0, 0, 0, 5'd15, 32'd15,        XLEN + 1);

      // Reset in the middle of a multiply
      @(posedge clock); #1;
      md_enable_ip = 1'b1; md_operator_ip = 3'd0; md_operand_a_ip = 32'd5; md_operand_b_ip = 32'd5;
      md_rd_addr_ip = 5'd21;
      repeat (6) @(posedge clock);
      #1;
      chk("rst_mid_busy_before", md_busy_op, 1);
      reset = 1'b1; md_enable_ip = 1'b0;
      @(posedge clock); #1;
      chk("rst_mid_res", md_result_op, 0);
      chk("rst_mid_vld", md_valid_op, 0);
      chk("rst_mid_rd", md_rd_addr_op, 0);
      chk("rst_mid_busy", md_busy_op, 0);
      chk("rst_mid_stall", stall_op, 0);
      reset = 1'b0;

      // Randomised operations against the reference model
      for (int n = 0; n < 40; n++) begin
         r_op = 3'($urandom_range(0, 7));
         r_a  = $urandom; r_b = $urandom; r_m = $urandom; r_w = $urandom;
         r_fa = 2'($urandom_range(0, 3)); r_fb = 2'($urandom_range(0, 3));
         case ($urandom_range(0, 5))
            0: begin r_fb = 2'd0; r_b = 32'd0; end
            1: r_b = 32'($urandom_range(1, 15));
            2: begin r_fa = 2'd0; r_fb = 2'd0; r_a = 32'h8000_0000; r_b = 32'hFFFF_FFFF; end
            default: ;
         endcase
         run_op($sformatf("rnd%0d_op%0d", n, r_op), r_op, r_a, r_b, r_fa, r_fb, r_m, r_w, 5'($urandom),
                ref_md(r_op, fwd_sel(r_fa, r_a, r_m, r_w), fwd_sel(r_fb, r_b, r_m, r_w)), 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
